ps2_key_controller: RTL and testbench
=====================================

PS2_KEY_CONTROLLER -- requirements
Module: ps2_key_controller

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning event queue entries (power of 2, 2..16).
REQ-002 SHALL have parameter PREFIX_TIMEOUT, default 50000, meaning Clk cycles a pending prefix survives without a following byte.
REQ-003 Clk  in  1  single system clock; all logic on posedge Clk.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Rx_Byte  in  8  scan byte from the PS2 receiver.
REQ-006 Rx_Valid  in  1  one-cycle strobe; Rx_Byte valid.
REQ-007 Rx_Err  in  1  qualifies Rx_Valid; byte had a parity/framing error.
REQ-008 Rd_En  in  1  consumer pops the head event.
REQ-009 Clr_Ovf  in  1  clears the Overflow flag.
REQ-010 Ev_Valid  out  1  queue non-empty.
REQ-011 Ev_Data  out  10  head event {Ext, Brk, Code[7:0]}.
REQ-012 Held_Key  out  8  code of the last pressed, not yet released key; 0x00 when none.
REQ-013 Overflow  out  1  sticky; an event was dropped.

Function
REQ-014 Decoder FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0 seen).
REQ-015 Transitions: IDLE--E0->EXT; IDLE--F0->BRK; EXT--F0->EXT_BRK; BRK--E0->EXT_BRK; EXT--E0->EXT; BRK--F0->BRK; EXT_BRK--E0/F0->EXT_BRK.
REQ-016 Any other byte in any state: push event {Ext=state in EXT/EXT_BRK, Brk=state in BRK/EXT_BRK, Code=Rx_Byte}, then return to IDLE.
REQ-017 Bytes 0x00, 0xAA, 0xFA, 0xFE, 0xFF: never queued, never touch Held_Key; FSM returns to IDLE.
REQ-018 Rx_Valid with Rx_Err=1: byte discarded, FSM to IDLE, no event.
REQ-019 Timeout counter reloads on every accepted byte; if the FSM stays outside IDLE for PREFIX_TIMEOUT cycles it returns to IDLE with no event.
REQ-020 Latency: Ev_Valid/Ev_Data reflect a pushed event on the cycle after the Rx_Valid of its final byte (registered, first-word fall-through).
REQ-021 Pop on Rd_En when Ev_Valid=1; Rd_En with empty queue is ignored.
REQ-022 Push while full and no pop in the same cycle: new event dropped, Overflow set.
REQ-023 Simultaneous push and pop while full: both occur, no overflow.
REQ-024 Simultaneous push and pop while empty: event is queued, pop is ignored.
REQ-025 Read/write pointers wrap modulo FIFO_DEPTH; occupancy count is log2(FIFO_DEPTH)+1 bits wide.
REQ-026 Held_Key: make event (Brk=0) loads Code; break event whose Code equals Held_Key clears it to 0x00; other breaks leave it unchanged.
REQ-027 Set and clear of Overflow in the same cycle: set wins.

Reset
REQ-028 Reset SHALL force FSM=IDLE, queue empty, Ev_Valid=0, Ev_Data=0x000, Held_Key=0x00, Overflow=0, timeout counter=0.
REQ-029 Reset mid-sequence (for example between F0 and code) SHALL abandon the prefix; the following code byte is treated as a make.
REQ-030 Inputs are ignored in the reset cycle.

Configuration
REQ-031 Macro PS2_TYPEMATIC_FILTER_EN: when defined, a make event whose Code and Ext equal the currently held key is not queued (auto-repeat suppressed); Held_Key still updates.
REQ-032 Without PS2_TYPEMATIC_FILTER_EN, every make event is queued, repeats included.

Verification
REQ-033 Bytes 1C, F0, 1C -> events 0x01C then 0x11C; Held_Key 1C then 00.
REQ-034 Bytes E0, F0, 75 -> single event 0x375; FSM back in IDLE.
REQ-035 Bytes 1C, 1C, 1C -> three events 0x01C without the macro, one event with it.
REQ-036 Push 5 make codes with no reads, FIFO_DEPTH=4 -> 4 events retained, Overflow=1; Clr_Ovf -> Overflow=0.
REQ-037 F0, then PREFIX_TIMEOUT idle cycles, then 1C -> event 0x01C (make); AA and FA bytes -> no events.
REQ-038 F0, then Rx_Valid with Rx_Err=1, then 1C -> event 0x01C; Reset asserted after F0 gives the same result.

Source files
------------

// File: rtl/ps2_key_controller.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into {Ext, Brk, Code} events, queues them, tracks
// the held key. Define PS2_TYPEMATIC_FILTER_EN to drop auto-repeat makes of the held key.
module ps2_key_controller #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned PREFIX_TIMEOUT = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Rx_Byte,
  input  logic       Rx_Valid,
  input  logic       Rx_Err,
  input  logic       Rd_En,
  input  logic       Clr_Ovf,
  output logic       Ev_Valid,
  output logic [9:0] Ev_Data,
  output logic [7:0] Held_Key,
  output logic       Overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned TW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    held_key_d;
  logic          held_ext_q, held_ext_d;
  logic [9:0]    head_d;

  logic          is_ext, is_brk, ev_gen, suppress, ev_push;
  logic          full, pop, wr_en, ovf_set;
  logic [9:0]    ev_word;

  assign is_ext = (state_q == StExt) || (state_q == StExtBrk);
  assign is_brk = (state_q == StBrk) || (state_q == StExtBrk);

  // Prefix decoder and timeout
  always_comb begin
    state_d = state_q;
    ev_gen  = 1'b0;
    ev_word = {is_ext, is_brk, Rx_Byte};
    if (Rx_Valid && Rx_Err) begin
      state_d = StIdle;
    end else if (Rx_Valid) begin
      case (Rx_Byte)
        8'hE0: state_d = is_brk ? StExtBrk : StExt;
        8'hF0: state_d = is_ext ? StExtBrk : StBrk;
        8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: state_d = StIdle;
        default: begin
          ev_gen  = 1'b1;
          state_d = StIdle;
        end
      endcase
    end else if (state_q != StIdle && tmo_q == TW'(PREFIX_TIMEOUT - 1)) begin
      state_d = StIdle;
    end
    tmo_d = (Rx_Valid || state_d == StIdle) ? '0 : tmo_q + TW'(1);
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign suppress = ev_gen && !is_brk && (Rx_Byte == Held_Key) && (is_ext == held_ext_q);
`else
  assign suppress = 1'b0;
`endif
  assign ev_push = ev_gen && !suppress;

  // Held key follows every decoded event, including repeats and dropped ones
  always_comb begin
    held_key_d = Held_Key;
    held_ext_d = held_ext_q;
    if (ev_gen && !is_brk) begin
      held_key_d = Rx_Byte;
      held_ext_d = is_ext;
    end else if (ev_gen && is_brk && Rx_Byte == Held_Key) begin
      held_key_d = 8'h00;
      held_ext_d = 1'b0;
    end
  end

  // Event queue with a registered head
  always_comb begin
    full     = (count_q == (AW + 1)'(FIFO_DEPTH));
    pop      = Rd_En && (count_q != '0);
    wr_en    = ev_push && (!full || pop);
    ovf_set  = ev_push && full && !pop;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d  = count_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    // An event written straight into the next head slot has to bypass the array
    if (count_d == '0) begin
      head_d = '0;
    end else if (wr_en && wr_ptr_q == rd_ptr_d) begin
      head_d = ev_word;
    end else begin
      head_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && wr_en) begin
      mem[wr_ptr_q] <= ev_word;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      tmo_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      Ev_Valid   <= 1'b0;
      Ev_Data    <= '0;
      Held_Key   <= 8'h00;
      held_ext_q <= 1'b0;
      Overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      Ev_Valid   <= (count_d != '0);
      Ev_Data    <= head_d;
      Held_Key   <= held_key_d;
      held_ext_q <= held_ext_d;
      if (ovf_set) begin
        Overflow <= 1'b1;
      end else if (Clr_Ovf) begin
        Overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_controller.sv
// Directed bench for ps2_key_controller: prefix decoding, held key, queue full/empty corners,
// prefix timeout, error bytes and mid-sequence reset.
module tb_ps2_key_controller;

  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 20;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Rx_Byte = 8'h00;
  logic       Rx_Valid = 1'b0;
  logic       Rx_Err = 1'b0;
  logic       Rd_En = 1'b0;
  logic       Clr_Ovf = 1'b0;
  logic       Ev_Valid;
  logic [9:0] Ev_Data;
  logic [7:0] Held_Key;
  logic       Overflow;

  int vectors = 0;
  int errors  = 0;

  ps2_key_controller #(
    .FIFO_DEPTH    (Depth),
    .PREFIX_TIMEOUT(Tmo)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Rx_Byte (Rx_Byte),
    .Rx_Valid(Rx_Valid),
    .Rx_Err  (Rx_Err),
    .Rd_En   (Rd_En),
    .Clr_Ovf (Clr_Ovf),
    .Ev_Valid(Ev_Valid),
    .Ev_Data (Ev_Data),
    .Held_Key(Held_Key),
    .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic send(input logic [7:0] b, input logic err, input logic rd, input logic clr);
    Rx_Byte = b; Rx_Valid = 1'b1; Rx_Err = err; Rd_En = rd; Clr_Ovf = clr;
    @(posedge Clk); #1;
    Rx_Valid = 1'b0; Rx_Err = 1'b0; Rd_En = 1'b0; Clr_Ovf = 1'b0;
  endtask

  task automatic pop();
    Rd_En = 1'b1;
    @(posedge Clk); #1;
    Rd_En = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    // Inputs are active during reset and must be ignored
    Reset = 1'b1; Rx_Byte = 8'h1C; Rx_Valid = 1'b1; Rd_En = 1'b1; Clr_Ovf = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0; Rx_Valid = 1'b0; Rd_En = 1'b0;
    vectors++;
    if (Ev_Valid !== 1'b0) begin
      errors++; $display("FAIL reset_ev_valid: got %b required 0", Ev_Valid);
    end
    vectors++;
    if (Ev_Data !== 10'h000) begin
      errors++; $display("FAIL reset_ev_data: got %h required 000", Ev_Data);
    end
    vectors++;
    if (Held_Key !== 8'h00) begin
      errors++; $display("FAIL reset_held_key: got %h required 00", Held_Key);
    end
    vectors++;
    if (Overflow !== 1'b0) begin
      errors++; $display("FAIL reset_overflow: got %b required 0", Overflow);
    end
  endtask

  task automatic test_make_break();
    logic [9:0] exp [2] = '{10'h01C, 10'h11C};
    send(8'h1C, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (Ev_Valid !== 1'b1 || Ev_Data !== 10'h01C) begin
      errors++; $display("FAIL make_latency: valid=%b data=%h required 1/01C", Ev_Valid, Ev_Data);
    end
    vectors++;
    if (Held_Key !== 8'h1C) begin
      errors++; $display("FAIL make_held: got %h required 1C", Held_Key);
    end
    send(8'hF0, 1'b0, 1'b0, 1'b0);
    send(8'h1C, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (Held_Key !== 8'h00) begin
      errors++; $display("FAIL break_held: got %h required 00", Held_Key);
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (Ev_Valid !== 1'b1 || Ev_Data !== exp[i]) begin
        errors++;
        $display("FAIL make_break_ev[%0d]: valid=%b data=%h required %h", i, Ev_Valid, Ev_Data,
                 exp[i]);
      end
      pop();
    end
    vectors++;
    if (Ev_Valid !== 1'b0) begin
      errors++; $display("FAIL make_break_empty: got %b required 0", Ev_Valid);
    end
  endtask

  task automatic test_ext_break();
    logic [9:0] exp [3] = '{10'h375, 10'h01C, 10'h11C};
    send(8'hE0, 1'b0, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b0, 1'b0);
    send(8'h75, 1'b0, 1'b0, 1'b0);
    // A plain code right after proves the decoder went back to idle
    send(8'h1C, 1'b0, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b0, 1'b0);
    send(8'h1C, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (Ev_Valid !== 1'b1 || Ev_Data !== exp[i]) begin
        errors++;
        $display("FAIL ext_break_ev[%0d]: valid=%b data=%h required %h", i, Ev_Valid, Ev_Data,
                 exp[i]);
      end
      pop();
    end
    vectors++;
    if (Ev_Valid !== 1'b0 || Held_Key !== 8'h00) begin
      errors++; $display("FAIL ext_break_end: valid=%b held=%h required 0/00", Ev_Valid, Held_Key);
    end
  endtask

  task automatic test_typematic();
    int n = 0;
    int exp_n;
`ifdef PS2_TYPEMATIC_FILTER_EN
    exp_n = 1;
`else
    exp_n = 3;
`endif
    do_reset();
    for (int i = 0; i < 3; i++) send(8'h1C, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (Held_Key !== 8'h1C) begin
      errors++; $display("FAIL repeat_held: got %h required 1C", Held_Key);
    end
    while (Ev_Valid === 1'b1 && n < 8) begin
      vectors++;
      if (Ev_Data !== 10'h01C) begin
        errors++; $display("FAIL repeat_data[%0d]: got %h required 01C", n, Ev_Data);
      end
      pop();
      n++;
    end
    vectors++;
    if (n != exp_n) begin
      errors++; $display("FAIL repeat_count: got %0d required %0d", n, exp_n);
    end
  endtask

  task automatic test_overflow();
    logic [9:0] exp [4] = '{10'h015, 10'h016, 10'h017, 10'h018};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(8'h15 + 8'(i), 1'b0, 1'b0, 1'b0);
      if (i == 3) begin
        vectors++;
        if (Overflow !== 1'b0) begin
          errors++; $display("FAIL ovf_at_full: got %b required 0", Overflow);
        end
      end
    end
    vectors++;
    if (Overflow !== 1'b1 || Ev_Valid !== 1'b1) begin
      errors++; $display("FAIL ovf_set: ovf=%b valid=%b required 1/1", Overflow, Ev_Valid);
    end
    Clr_Ovf = 1'b1;
    @(posedge Clk); #1;
    Clr_Ovf = 1'b0;
    vectors++;
    if (Overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b required 0", Overflow);
    end
    send(8'h27, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (Overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set_wins: got %b required 1", Overflow);
    end
    Clr_Ovf = 1'b1;
    @(posedge Clk); #1;
    Clr_Ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (Ev_Valid !== 1'b1 || Ev_Data !== exp[i]) begin
        errors++;
        $display("FAIL ovf_keep[%0d]: valid=%b data=%h required %h", i, Ev_Valid, Ev_Data,
                 exp[i]);
      end
      pop();
    end
    vectors++;
    if (Ev_Valid !== 1'b0 || Overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_end: valid=%b ovf=%b required 0/0", Ev_Valid, Overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp [4] = '{10'h022, 10'h023, 10'h024, 10'h025};
    do_reset();
    for (int i = 0; i < 4; i++) send(8'h21 + 8'(i), 1'b0, 1'b0, 1'b0);
    send(8'h25, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (Overflow !== 1'b0 || Ev_Data !== 10'h022) begin
      errors++; $display("FAIL full_push_pop: ovf=%b data=%h required 0/022", Overflow, Ev_Data);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (Ev_Valid !== 1'b1 || Ev_Data !== exp[i]) begin
        errors++;
        $display("FAIL b2b_drain[%0d]: valid=%b data=%h required %h", i, Ev_Valid, Ev_Data,
                 exp[i]);
      end
      pop();
    end
    vectors++;
    if (Ev_Valid !== 1'b0) begin
      errors++; $display("FAIL b2b_empty: got %b required 0", Ev_Valid);
    end
    send(8'h26, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (Ev_Valid !== 1'b1 || Ev_Data !== 10'h026) begin
      errors++;
      $display("FAIL empty_push_pop: valid=%b data=%h required 1/026", Ev_Valid, Ev_Data);
    end
    pop();
    pop();
    vectors++;
    if (Ev_Valid !== 1'b0 || Ev_Data !== 10'h000) begin
      errors++; $display("FAIL pop_empty: valid=%b data=%h required 0/000", Ev_Valid, Ev_Data);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send(8'hF0, 1'b0, 1'b0, 1'b0);
    idle(Tmo);
    send(8'h1C, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (Ev_Valid !== 1'b1 || Ev_Data !== 10'h01C) begin
      errors++; $display("FAIL timeout_make: valid=%b data=%h required 1/01C", Ev_Valid, Ev_Data);
    end
    pop();
    // One cycle short of the timeout, the prefix must still apply
    send(8'hF0, 1'b0, 1'b0, 1'b0);
    idle(Tmo - 1);
    send(8'h1C, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (Ev_Valid !== 1'b1 || Ev_Data !== 10'h11C) begin
      errors++; $display("FAIL timeout_edge: valid=%b data=%h required 1/11C", Ev_Valid, Ev_Data);
    end
    pop();
    send(8'h33, 1'b0, 1'b0, 1'b0);
    pop();
    send(8'hF0, 1'b0, 1'b0, 1'b0);
    send(8'hAA, 1'b0, 1'b0, 1'b0);
    send(8'hFA, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (Ev_Valid !== 1'b0 || Held_Key !== 8'h33) begin
      errors++; $display("FAIL ignored_bytes: valid=%b held=%h required 0/33", Ev_Valid, Held_Key);
    end
    send(8'h34, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (Ev_Data !== 10'h034 || Held_Key !== 8'h34) begin
      errors++; $display("FAIL after_ignored: data=%h held=%h required 034/34", Ev_Data, Held_Key);
    end
    pop();
  endtask

  task automatic test_error_and_reset();
    do_reset();
    send(8'hF0, 1'b0, 1'b0, 1'b0);
    send(8'h1C, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (Ev_Valid !== 1'b0) begin
      errors++; $display("FAIL err_byte: valid=%b required 0", Ev_Valid);
    end
    send(8'h1C, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (Ev_Valid !== 1'b1 || Ev_Data !== 10'h01C) begin
      errors++; $display("FAIL err_then_code: valid=%b data=%h required 1/01C", Ev_Valid, Ev_Data);
    end
    pop();
    send(8'hF0, 1'b0, 1'b0, 1'b0);
    do_reset();
    send(8'h1C, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (Ev_Valid !== 1'b1 || Ev_Data !== 10'h01C || Held_Key !== 8'h1C) begin
      errors++;
      $display("FAIL reset_mid_seq: valid=%b data=%h held=%h required 1/01C/1C", Ev_Valid,
               Ev_Data, Held_Key);
    end
    pop();
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_ext_break();
    test_typematic();
    test_overflow();
    test_back_to_back();
    test_timeout();
    test_error_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
